// File: rtl/mandala_pkg.sv
// mandala_pkg: shared FSM encoding, cfg register map, ctrl bit positions and reset values
package mandala_pkg;
  typedef enum logic [1:0] {ST_ACTIVE, ST_COMMIT, ST_ADVANCE} state_e;
  localparam logic [1:0] A_CTRL = 2'd0;
  localparam logic [1:0] A_MASK = 2'd1;
  localparam logic [1:0] A_PAT  = 2'd2;
  localparam logic [1:0] A_COL  = 2'd3;
  localparam int C_RUN  = 7;
  localparam int C_STEP = 6;
  localparam int C_DIR  = 5;
  localparam logic [7:0] RST_CTRL = 8'h81;
  localparam logic [7:0] RST_MASK = 8'hFF;
  localparam logic [7:0] RST_PAT  = 8'h00;
  localparam logic [7:0] RST_COL  = 8'h00;
endpackage

// File: rtl/mandala_anim_ctrl.sv
// mandala_anim_ctrl: frame-synchronous commit of shadowed host config and per-frame pattern/colour animation
module mandala_anim_ctrl
  import mandala_pkg::*;
#(
  parameter int FRAME_DIV = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [1:0]  cfg_addr,
  input  logic [7:0]  cfg_data,
  output logic [7:0]  pattern_offset,
  output logic [5:0]  color_base,
  output logic [7:0]  layer_mask,
  output logic        update_strobe,
  output logic [15:0] frame_count
);
  state_e      state_q, state_d;
  logic [7:0]  live_q [4];
  logic [7:0]  live_d [4];
  logic [7:0]  sh_q [4];
  logic [7:0]  sh_d [4];
  logic [3:0]  dirty_q, dirty_d;
  logic [7:0]  div_q, div_d;
  logic        due_q, due_d;
  logic [1:0]  pre_q;
  logic        chg_q, adv, diff;
  logic [7:0]  spd;
  logic [15:0] fc_q;
  assign cfg_ready      = state_q != ST_COMMIT;
  assign spd            = {4'd0, live_q[A_CTRL][3:0]};
  assign adv            = state_q == ST_ADVANCE && due_q && (live_q[A_CTRL][C_RUN] || live_q[A_CTRL][C_STEP]);
  assign diff           = live_d[A_PAT] != live_q[A_PAT] || live_d[A_MASK] != live_q[A_MASK] ||
                          live_d[A_COL][7:2] != live_q[A_COL][7:2];
  assign update_strobe  = state_q == ST_ADVANCE && (chg_q || diff);
  assign pattern_offset = live_q[A_PAT];
  assign color_base     = live_q[A_COL][7:2];
  assign layer_mask     = live_q[A_MASK];
  assign frame_count    = fc_q;
  always_comb begin
    state_d = state_q;
    live_d  = live_q;
    sh_d    = sh_q;
    dirty_d = dirty_q;
    div_d   = div_q;
    due_d   = due_q;
    if (cfg_valid && cfg_ready) begin
      sh_d[cfg_addr]    = cfg_data;
      dirty_d[cfg_addr] = 1'b1;
    end
    case (state_q)
      ST_ACTIVE: if (frame_tick) begin
        state_d = ST_COMMIT;
        due_d   = div_q == 8'(FRAME_DIV - 1);
        div_d   = due_d ? 8'd0 : div_q + 8'd1;
      end
      ST_COMMIT: begin
        state_d = ST_ADVANCE;
        for (int i = 0; i < 4; i++) live_d[i] = dirty_q[i] ? sh_q[i] : live_q[i];
        dirty_d = '0;
      end
      ST_ADVANCE: begin
        state_d = ST_ACTIVE;
        // a preset committed this frame takes precedence over the animation step
        if (adv) begin
          live_d[A_PAT] = pre_q[0] ? live_q[A_PAT] :
                          live_q[A_CTRL][C_DIR] ? live_q[A_PAT] - spd : live_q[A_PAT] + spd;
          live_d[A_COL] = pre_q[1] ? live_q[A_COL] : live_q[A_COL] + 8'd1;
          live_d[A_CTRL][C_STEP] = 1'b0;
        end
      end
      default: state_d = ST_ACTIVE;
    endcase
  end
  // pre_q/chg_q sampled every cycle; only their COMMIT-cycle values are consumed in ADVANCE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_ACTIVE;
      live_q  <= '{RST_CTRL, RST_MASK, RST_PAT, RST_COL};
      sh_q    <= '{RST_CTRL, RST_MASK, RST_PAT, RST_COL};
      dirty_q <= '0;
      div_q   <= '0;
      due_q   <= 1'b0;
      pre_q   <= '0;
      chg_q   <= 1'b0;
      fc_q    <= '0;
    end else begin
      state_q <= state_d;
      live_q  <= live_d;
      sh_q    <= sh_d;
      dirty_q <= dirty_d;
      div_q   <= div_d;
      due_q   <= due_d;
      pre_q   <= {dirty_q[A_COL], dirty_q[A_PAT]};
      chg_q   <= diff;
      fc_q    <= frame_tick ? fc_q + 16'd1 : fc_q;
    end
  end
endmodule

// File: tb/tb_mandala_anim_ctrl.sv
// tb_mandala_anim_ctrl: table-driven and directed checks of frame commit/advance behaviour
module tb_mandala_anim_ctrl;
  logic        clk = 1'b0, reset = 1'b1, frame_tick = 1'b0, cfg_valid = 1'b0;
  logic [1:0]  cfg_addr = '0;
  logic [7:0]  cfg_data = '0;
  logic        rdy1, upd1, rdy4, upd4;
  logic [7:0]  pat1, mask1, pat4, mask4;
  logic [5:0]  col1, col4;
  logic [15:0] fc1, fc4;
  int          checks = 0, errors = 0, rlow;
  bit          stb1, stb4;

  typedef struct {
    bit         wr;
    logic [1:0] a;
    logic [7:0] d;
    bit         tk;
    logic [7:0] pat;
    logic [5:0] col;
    logic [7:0] mask;
    bit         stb;
  } vec_t;
  vec_t tbl [15];

  always #5 clk = ~clk;

  mandala_anim_ctrl #(.FRAME_DIV(1)) dut1 (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .cfg_valid(cfg_valid), .cfg_ready(rdy1),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .pattern_offset(pat1), .color_base(col1),
    .layer_mask(mask1), .update_strobe(upd1), .frame_count(fc1));

  mandala_anim_ctrl #(.FRAME_DIV(4)) dut4 (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .cfg_valid(cfg_valid), .cfg_ready(rdy4),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .pattern_offset(pat4), .color_base(col4),
    .layer_mask(mask4), .update_strobe(upd4), .frame_count(fc4));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", n, act, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    cfg_valid = 1'b1;
    cfg_addr  = a;
    cfg_data  = d;
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic do_frame(input bit ws, input logic [1:0] a, input logic [7:0] d);
    frame_tick = 1'b1;
    cfg_valid  = ws;
    cfg_addr   = a;
    cfg_data   = d;
    stb1 = 1'b0;
    stb4 = 1'b0;
    rlow = 0;
    step();
    frame_tick = 1'b0;
    cfg_valid  = 1'b0;
    repeat (3) begin
      rlow += int'(!rdy1);
      stb1 |= upd1;
      stb4 |= upd4;
      step();
    end
  endtask

  initial begin
    tbl[0]  = '{1'b0, 2'd0, 8'h00, 1'b1, 8'h01, 6'h00, 8'hFF, 1'b1};
    tbl[1]  = '{1'b0, 2'd0, 8'h00, 1'b1, 8'h02, 6'h00, 8'hFF, 1'b1};
    tbl[2]  = '{1'b0, 2'd0, 8'h00, 1'b1, 8'h03, 6'h00, 8'hFF, 1'b1};
    tbl[3]  = '{1'b0, 2'd0, 8'h00, 1'b1, 8'h04, 6'h01, 8'hFF, 1'b1};
    tbl[4]  = '{1'b1, 2'd0, 8'h23, 1'b0, 8'h04, 6'h01, 8'hFF, 1'b0};
    tbl[5]  = '{1'b1, 2'd0, 8'hA3, 1'b0, 8'h04, 6'h01, 8'hFF, 1'b0};
    tbl[6]  = '{1'b1, 2'd2, 8'h02, 1'b1, 8'h02, 6'h01, 8'hFF, 1'b1};
    tbl[7]  = '{1'b0, 2'd0, 8'h00, 1'b1, 8'hFF, 6'h01, 8'hFF, 1'b1};
    tbl[8]  = '{1'b0, 2'd0, 8'h00, 1'b1, 8'hFC, 6'h01, 8'hFF, 1'b1};
    tbl[9]  = '{1'b1, 2'd3, 8'hFC, 1'b1, 8'hF9, 6'h3F, 8'hFF, 1'b1};
    tbl[10] = '{1'b0, 2'd0, 8'h00, 1'b1, 8'hF6, 6'h3F, 8'hFF, 1'b1};
    tbl[11] = '{1'b1, 2'd0, 8'h41, 1'b1, 8'hF7, 6'h3F, 8'hFF, 1'b1};
    tbl[12] = '{1'b0, 2'd0, 8'h00, 1'b1, 8'hF7, 6'h3F, 8'hFF, 1'b0};
    tbl[13] = '{1'b0, 2'd0, 8'h00, 1'b1, 8'hF7, 6'h3F, 8'hFF, 1'b0};
    tbl[14] = '{1'b1, 2'd0, 8'h81, 1'b0, 8'hF7, 6'h3F, 8'hFF, 1'b0};

    repeat (3) step();
    reset = 1'b0;
    step();
    chk("rst pat", pat1, 8'h00);
    chk("rst col", col1, 6'h00);
    chk("rst mask", mask1, 8'hFF);
    chk("rst strobe", upd1, 1'b0);
    chk("rst fc", fc1, 16'd0);
    chk("rst ready", rdy1, 1'b1);

    for (int i = 0; i < 15; i++) begin
      if (tbl[i].wr) wr(tbl[i].a, tbl[i].d);
      if (tbl[i].tk) do_frame(1'b0, 2'd0, 8'h00);
      else stb1 = upd1;
      chk($sformatf("v%0d pat", i), pat1, tbl[i].pat);
      chk($sformatf("v%0d col", i), col1, tbl[i].col);
      chk($sformatf("v%0d mask", i), mask1, tbl[i].mask);
      chk($sformatf("v%0d strobe", i), stb1, tbl[i].stb);
      if (i == 3) chk("fc after 4", fc1, 16'd4);
    end

    wr(2'd1, 8'h0F);
    repeat (3) step();
    chk("mask held", mask1, 8'hFF);
    do_frame(1'b0, 2'd0, 8'h00);
    chk("ready low cycles", rlow, 1);
    chk("mask commit", mask1, 8'h0F);
    chk("mask frame pat", pat1, 8'hF8);
    chk("mask frame strobe", stb1, 1'b1);
    chk("fc 13", fc1, 16'd13);

    do_frame(1'b1, 2'd2, 8'h80);
    chk("same-cycle pat", pat1, 8'h80);
    chk("same-cycle col", col1, 6'h00);
    chk("same-cycle strobe", stb1, 1'b1);

    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    step();
    cfg_valid = 1'b1;
    cfg_addr  = 2'd2;
    cfg_data  = 8'h40;
    chk("advance ready", rdy1, 1'b1);
    step();
    cfg_valid = 1'b0;
    chk("deferred pat", pat1, 8'h81);
    do_frame(1'b0, 2'd0, 8'h00);
    chk("deferred commit pat", pat1, 8'h40);
    chk("deferred col", col1, 6'h00);
    chk("fc 16", fc1, 16'd16);

    frame_tick = 1'b1;
    step();
    step();
    frame_tick = 1'b0;
    step();
    chk("tick in commit pat", pat1, 8'h41);
    chk("tick in commit fc", fc1, 16'd18);

    frame_tick = 1'b1;
    repeat (65536) step();
    frame_tick = 1'b0;
    repeat (3) step();
    chk("fc wrap", fc1, 16'd18);

    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    step();
    for (int i = 1; i <= 8; i++) begin
      do_frame(1'b0, 2'd0, 8'h00);
      chk($sformatf("div4 t%0d pat", i), pat4, 8'(i / 4));
      chk($sformatf("div4 t%0d strobe", i), stb4, (i % 4) == 0);
    end
    repeat (3) do_frame(1'b0, 2'd0, 8'h00);
    chk("div4 t11 pat", pat4, 8'h02);
    wr(2'd1, 8'h0F);
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    chk("div4 commit ready", rdy4, 1'b0);
    reset = 1'b1;
    #1;
    chk("async rst pat", pat4, 8'h00);
    chk("async rst mask", mask4, 8'hFF);
    chk("async rst strobe", upd4, 1'b0);
    chk("async rst fc", fc4, 16'd0);
    step();
    reset = 1'b0;
    step();
    chk("post rst ready", rdy4, 1'b1);
    chk("post rst mask", mask4, 8'hFF);
    chk("post rst pat", pat4, 8'h00);
    chk("post rst col", col4, 6'h00);
    chk("post rst fc", fc4, 16'd0);
    do_frame(1'b0, 2'd0, 8'h00);
    chk("post rst div4 pat", pat4, 8'h00);
    chk("post rst div4 fc", fc4, 16'd1);
    chk("post rst div1 pat", pat1, 8'h01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mandala_anim_ctrl.md
MANDALA_ANIM_CTRL -- requirements
Module: mandala_anim_ctrl

Interface
REQ-001 SHALL have parameter FRAME_DIV, default 1, meaning frame_tick pulses per animation step (legal range 1..255).
REQ-002 SHALL have ports: clk  input  1  pixel clock.
REQ-003 SHALL have: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have: frame_tick  input  1  one-cycle pulse at the first blanking line (vpos==480, hpos==0).
REQ-005 SHALL have: cfg_valid  input  1  host write request.
REQ-006 SHALL have: cfg_ready  output  1  write accepted when cfg_valid && cfg_ready.
REQ-007 SHALL have: cfg_addr  input  2  register select: 0 ctrl, 1 layer_mask, 2 pattern preset, 3 color preset.
REQ-008 SHALL have: cfg_data  input  8  write data; ctrl = {run[7], step[6], dir[5], rsvd[4], speed[3:0]}.
REQ-009 SHALL have: pattern_offset  output  8  angle offset to mandala datapath.
REQ-010 SHALL have: color_base  output  6  palette base, = color_phase[7:2].
REQ-011 SHALL have: layer_mask  output  8  per-ring enable, bit n = layer n+1.
REQ-012 SHALL have: update_strobe  output  1  one-cycle pulse when live values change.
REQ-013 SHALL have: frame_count  output  16  frame_tick count since reset.

Function
REQ-014 SHALL implement FSM ACTIVE -> COMMIT -> ADVANCE -> ACTIVE; leave ACTIVE only on frame_tick; COMMIT and ADVANCE last exactly one cycle each.
REQ-015 SHALL hold cfg_ready = 0 in COMMIT only, 1 otherwise (including the cycle after reset release).
REQ-016 SHALL store accepted writes in shadow registers and set a per-address dirty flag; last write before COMMIT wins.
REQ-017 SHALL, in COMMIT, copy dirty shadow values to live registers and clear dirty flags; clean addresses keep live values.
REQ-018 SHALL, on a write accepted in the same cycle as frame_tick, include that write in the following COMMIT.
REQ-019 SHALL, on writes accepted in ADVANCE, defer them to the next frame's COMMIT.
REQ-020 SHALL ignore frame_tick in COMMIT/ADVANCE; frame_count still increments on every frame_tick.
REQ-021 SHALL keep an 8-bit divider counting frame_ticks; step is due when divider reaches FRAME_DIV-1, then divider returns to 0.
REQ-022 SHALL, in ADVANCE with step due and (run==1 or step pending), set pattern_offset += speed (dir=0) or -= speed (dir=1), modulo 256, and color_phase += 1 modulo 256.
REQ-023 SHALL skip the pattern increment in ADVANCE if a pattern preset was committed this frame; the same rule applies to color_phase.
REQ-024 SHALL treat ctrl step bit as self-clearing: set by commit, cleared after one performed advance; ignored while run==1.
REQ-025 SHALL pulse update_strobe in the ADVANCE cycle iff any live output changed during COMMIT or ADVANCE.
REQ-026 SHALL change pattern_offset, color_base and layer_mask only in COMMIT/ADVANCE, never during ACTIVE.
REQ-027 SHALL wrap frame_count from 16'hFFFF to 0.

Reset
REQ-028 SHALL, on reset, immediately set: state ACTIVE, pattern_offset 0, color_phase 0, layer_mask 8'hFF, ctrl run=1/step=0/dir=0/speed=1, divider 0, dirty flags 0, shadows equal live, update_strobe 0, frame_count 0.
REQ-029 SHALL, on reset asserted mid-COMMIT/ADVANCE, discard the partial update with no strobe.

Structure
REQ-030 SHALL place state encoding, cfg address constants, ctrl bit positions and reset values in shared package mandala_pkg.
REQ-031 SHALL be a single module; frame_tick generation stays in the sync generator.

Verification
REQ-032 Reset, 4 frame_ticks, FRAME_DIV=1 -> pattern_offset 0,1,2,3,4; color_base 0; update_strobe 4 pulses; frame_count 4.
REQ-033 Write ctrl=8'h23 (run=0... dir=1, speed=3) then 8'hA3, tick from pattern 2 -> pattern 255 (wrap), color_phase increments.
REQ-034 Write addr2=8'h80 same cycle as frame_tick -> after ADVANCE pattern_offset=8'h80, no increment that frame, strobe=1.
REQ-035 run=0, write ctrl step=1 speed=1, 3 ticks -> pattern advances exactly once; no strobe on ticks 2-3.
REQ-036 Write layer_mask=8'h0F mid-frame -> layer_mask stays 8'hFF until COMMIT, then 8'h0F; cfg_ready low exactly 1 cycle.
REQ-037 FRAME_DIV=4, 8 ticks; reset asserted during a COMMIT -> pattern advances every 4th tick; after reset all outputs per REQ-028.
